// File: rtl/wb_writer.sv
// wb_writer: register-file write-back arbiter.
// Merges an unstallable-by-default ALU result stream with a queued stream of
// load results into a single registered register-file write port. The ALU has
// priority, but a starvation counter forces queue pops once the ALU has won
// STARVE_LIMIT times in a row while loads are waiting.
//
// Handshake: the load port is valid/ready. A load result transfers on a rising
// edge where load_valid and load_ready are both high. load_valid may be held
// while load_ready is low and the offer simply waits. load_ready depends only on
// registered occupancy, so it never combinationally depends on load_valid. The
// ALU port has no ready; the only back-pressure is stall_alu, and an ALU request
// made while stall_alu is high is lost and recorded in err_drop.
module wb_writer #(
  parameter int DATAWIDTH    = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_rd,
  input  logic [DATAWIDTH-1:0]         alu_data,
  output logic                         stall_alu,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [4:0]                   load_rd,
  input  logic [DATAWIDTH-1:0]         load_data,
  output logic                         write,
  output logic [4:0]                   writeReg,
  output logic [DATAWIDTH-1:0]         writeData,
  output logic [$clog2(DEPTH):0]       pending,
  output logic                         err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_Q    = 2'd2
  } gnt_t;

  // Queue storage and bookkeeping.
  logic [4:0]           r_mem_rd   [DEPTH];
  logic [DATAWIDTH-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Starvation counter and sticky drop flag.
  logic [STV_W-1:0]     r_starve;
  logic                 r_err_drop;

  // Registered write port.
  logic                 r_write;
  logic [4:0]           r_write_reg;
  logic [DATAWIDTH-1:0] r_write_data;

  // Combinational decode.
  logic                 w_full;
  logic                 w_empty;
  logic                 w_stall;
  logic                 w_alu_req;
  logic                 w_push;
  logic                 w_pop;
  gnt_t                 w_gnt;
  logic [4:0]           w_head_rd;
  logic [DATAWIDTH-1:0] w_head_data;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [STV_W-1:0]     w_starve_nxt;

  // Status flags derived from registered state only.
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == '0);
    w_stall     = (r_starve == STARVE_MAX);
    w_alu_req   = alu_valid && (alu_rd != 5'd0);
    w_head_rd   = r_mem_rd[r_rd_ptr];
    w_head_data = r_mem_data[r_rd_ptr];
  end

  // Arbitration: forced pop under stall, else ALU, else queue, else idle.
  always_comb begin
    w_gnt = GNT_IDLE;
    if (w_stall) begin
      // The counter clears whenever the queue is empty, so a stall always has
      // a head to pop; the idle fallback only keeps the ALU locked out.
      w_gnt = w_empty ? GNT_IDLE : GNT_Q;
    end else if (w_alu_req) begin
      w_gnt = GNT_ALU;
    end else if (!w_empty) begin
      w_gnt = GNT_Q;
    end
  end

  // Queue transfer strobes and next occupancy.
  always_comb begin
    w_push      = load_valid && !w_full;
    w_pop       = (w_gnt == GNT_Q);
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next starvation count: cleared by any pop or an empty queue, otherwise
  // counts ALU wins that left loads waiting, saturating at the limit.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if ((w_gnt == GNT_ALU) && (r_starve != STARVE_MAX)) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end
  end

  // Queue payload storage; contents need no reset because occupancy gates use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= load_rd;
      r_mem_data[r_wr_ptr] <= load_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Starvation counter and sticky record of ALU results lost to a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve   <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_stall && w_alu_req) r_err_drop <= 1'b1;
    end
  end

  // Registered write port; address/data hold unless a real write happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      case (w_gnt)
        GNT_ALU: begin
          r_write      <= 1'b1;
          r_write_reg  <= alu_rd;
          r_write_data <= alu_data;
        end
        GNT_Q: begin
          // A load targeting x0 is drained without touching the register file.
          r_write <= (w_head_rd != 5'd0);
          if (w_head_rd != 5'd0) begin
            r_write_reg  <= w_head_rd;
            r_write_data <= w_head_data;
          end
        end
        default: r_write <= 1'b0;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    stall_alu  = w_stall;
    load_ready = !w_full;
    write      = r_write;
    writeReg   = r_write_reg;
    writeData  = r_write_data;
    pending    = r_count;
    err_drop   = r_err_drop;
  end

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed bench for wb_writer with hand-computed expectations.
module tb_wb_writer;

  localparam int DW = 32;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n;
  always #5 clk = ~clk;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          stall_alu;
  logic          load_valid;
  logic          load_ready;
  logic [4:0]    load_rd;
  logic [DW-1:0] load_data;
  logic          write;
  logic [4:0]    writeReg;
  logic [DW-1:0] writeData;
  logic [2:0]    pending;
  logic          err_drop;

  int n_checks = 0;
  int n_errors = 0;

  wb_writer #(.DATAWIDTH(DW), .DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .stall_alu  (stall_alu),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_rd    (load_rd),
    .load_data  (load_data),
    .write      (write),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .pending    (pending),
    .err_drop   (err_drop)
  );

  // Scoreboard compare
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic w, input logic [4:0] r, input logic [DW-1:0] d);
    check_val({tag, "_write"}, 64'(write), 64'(w));
    check_val({tag, "_reg"},   64'(writeReg), 64'(r));
    check_val({tag, "_data"},  64'(writeData), 64'(d));
  endtask

  initial begin
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    load_valid = 1'b0;
    load_rd    = '0;
    load_data  = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;

    // Reset state
    step();
    step();
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check_val("rst_pending", 64'(pending), 64'd0);
    check_val("rst_stall", 64'(stall_alu), 64'd0);
    check_val("rst_err", 64'(err_drop), 64'd0);
    check_val("rst_ready", 64'(load_ready), 64'd1);
    rst_n = 1'b1;
    step();
    check_val("post_rst_idle", 64'(write), 64'd0);

    // Single ALU write, then idle holds address/data
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    check_wr("alu5", 1'b1, 5'd5, 32'h1234);
    alu_valid = 1'b0;
    step();
    check_wr("idle_hold", 1'b0, 5'd5, 32'h1234);

    // Loads 1..4 stream through in order
    for (int k = 1; k <= 4; k++) begin
      load_valid = 1'b1; load_rd = 5'(k); load_data = 32'(32'hA0 + k);
      step();
      if (k == 1) begin
        check_val("ld_first_write", 64'(write), 64'd0);
      end else begin
        check_wr($sformatf("ld%0d", k - 1), 1'b1, 5'(k - 1), 32'(32'hA0 + k - 1));
      end
      check_val($sformatf("ld_pending%0d", k), 64'(pending), 64'd1);
    end
    load_valid = 1'b0;
    step();
    check_wr("ld4", 1'b1, 5'd4, 32'hA4);
    check_val("ld_pending_end", 64'(pending), 64'd0);
    step();
    check_val("ld_idle", 64'(write), 64'd0);

    // Fill the queue while the ALU keeps winning
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'(32'h900 + k);
      load_valid = 1'b1; load_rd = 5'(11 + k); load_data = 32'(32'hB0 + k);
      step();
      check_wr($sformatf("fill_alu%0d", k), 1'b1, 5'd9, 32'(32'h900 + k));
      check_val($sformatf("fill_pending%0d", k), 64'(pending), 64'(k + 1));
      check_val($sformatf("fill_stall%0d", k), 64'(stall_alu), 64'(k == 3));
      check_val($sformatf("fill_ready%0d", k), 64'(load_ready), 64'(k != 3));
    end
    // Full: offered load must be refused while the forced pop happens
    alu_valid = 1'b0;
    load_rd = 5'd15; load_data = 32'hFF;
    step();
    check_wr("full_pop", 1'b1, 5'd11, 32'hB0);
    check_val("full_pending", 64'(pending), 64'd3);
    check_val("full_ready_after", 64'(load_ready), 64'd1);
    check_val("full_stall_clr", 64'(stall_alu), 64'd0);
    load_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      check_wr($sformatf("drain%0d", j), 1'b1, 5'(11 + j), 32'(32'hB0 + j));
      check_val($sformatf("drain_pending%0d", j), 64'(pending), 64'(3 - j));
    end
    check_val("drain_err", 64'(err_drop), 64'd0);

    // x0 load popped silently while ALU offers an x0 non-request
    load_valid = 1'b1; load_rd = 5'd0; load_data = 32'hDEAD;
    step();
    check_val("x0_push_write", 64'(write), 64'd0);
    check_val("x0_push_pending", 64'(pending), 64'd1);
    load_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
    step();
    check_val("x0_pop_write", 64'(write), 64'd0);
    check_val("x0_pop_pending", 64'(pending), 64'd0);
    check_val("x0_err", 64'(err_drop), 64'd0);
    alu_valid = 1'b0;

    // Starvation: load rd=7 waits behind an always-valid ALU
    load_valid = 1'b1; load_rd = 5'd7; load_data = 32'h77;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h901;
    step();
    check_wr("stv1", 1'b1, 5'd9, 32'h901);
    check_val("stv1_pending", 64'(pending), 64'd1);
    load_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      alu_data = 32'(32'h900 + k);
      step();
      check_wr($sformatf("stv%0d", k), 1'b1, 5'd9, 32'(32'h900 + k));
      check_val($sformatf("stv%0d_stall", k), 64'(stall_alu), 64'(k == 4));
    end
    check_val("stv_err_before", 64'(err_drop), 64'd0);
    alu_data = 32'h905;
    step();
    check_wr("stv_pop7", 1'b1, 5'd7, 32'h77);
    check_val("stv_err_after", 64'(err_drop), 64'd1);
    check_val("stv_stall_clr", 64'(stall_alu), 64'd0);
    check_val("stv_pending", 64'(pending), 64'd0);
    alu_data = 32'h906;
    step();
    check_wr("stv_alu_resume", 1'b1, 5'd9, 32'h906);
    check_val("stv_resume_stall", 64'(stall_alu), 64'd0);

    // Mid-operation reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'(32'hC0 + k);
      load_valid = 1'b1; load_rd = 5'(20 + k); load_data = 32'(32'hD0 + k);
      step();
    end
    check_val("mr_pending_pre", 64'(pending), 64'd3);
    alu_valid = 1'b0; load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_wr("mr_async", 1'b0, 5'd0, 32'h0);
    check_val("mr_pending", 64'(pending), 64'd0);
    check_val("mr_stall", 64'(stall_alu), 64'd0);
    check_val("mr_err", 64'(err_drop), 64'd0);
    check_val("mr_ready", 64'(load_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check_val("mr_no_stale1", 64'(write), 64'd0);
    check_val("mr_pending_post", 64'(pending), 64'd0);
    step();
    check_val("mr_no_stale2", 64'(write), 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    step();
    check_wr("mr_alu3", 1'b1, 5'd3, 32'h33);
    alu_valid = 1'b0;

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of the result data and the register-file write data.
REQ-002 Parameter DEPTH, default 4 (power of 2, minimum 2): number of entries in the load-result queue.
REQ-003 Parameter STARVE_LIMIT, default 3 (minimum 1): number of consecutive ALU-won cycles with a non-empty queue before the ALU is stalled.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 alu_valid  in  1  ALU result present this cycle; the ALU cannot be back-pressured except through stall_alu.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_data  in  DATAWIDTH  ALU result.
REQ-009 stall_alu  out  1  instructs the ALU not to present a result this cycle.
REQ-010 load_valid  in  1  load result offered.
REQ-011 load_ready  out  1  queue accepts the offered load result.
REQ-012 load_rd  in  5  load destination register.
REQ-013 load_data  in  DATAWIDTH  loaded data.
REQ-014 write  out  1  register-file write enable (registered).
REQ-015 writeReg  out  5  register-file write address (registered).
REQ-016 writeData  out  DATAWIDTH  register-file write data (registered).
REQ-017 pending  out  clog2(DEPTH)+1  current queue occupancy.
REQ-018 err_drop  out  1  sticky flag: an ALU result arrived while stall_alu was high.

Function
REQ-019 load_ready SHALL equal NOT full, computed from registered occupancy only; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-020 A load result SHALL be enqueued on a rising edge where load_valid AND load_ready is true; entries with load_rd = 0 SHALL still be queued.
REQ-021 An ALU request SHALL exist only when alu_valid = 1 and alu_rd != 0; alu_valid with alu_rd = 0 SHALL be treated as no request.
REQ-022 Arbitration each cycle, in priority order:
- stall_alu = 1: pop the queue head.
- Otherwise, an ALU request exists: ALU wins.
- Otherwise, the queue is non-empty: pop the queue head.
- Otherwise: idle.
REQ-023 A winner SHALL drive write/writeReg/writeData on the next rising edge (latency 1 cycle); write = 1 only if the winner's rd != 0.
REQ-024 A popped entry with rd = 0 SHALL be removed from the queue with write = 0 for that cycle.
REQ-025 Idle cycles SHALL drive write = 0; writeReg and writeData SHALL hold their previous values.
REQ-026 Enqueue and pop in the same cycle SHALL leave pending unchanged; the read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Starvation counter behaviour:
- Increments when the ALU wins while the queue is non-empty.
- Clears to 0 on any pop or when the queue is empty.
- Saturates at STARVE_LIMIT.
REQ-028 stall_alu SHALL be 1 exactly when the counter equals STARVE_LIMIT; the queue is then necessarily non-empty.
REQ-029 An ALU request during stall_alu = 1 SHALL be discarded and SHALL set err_drop, which stays set until reset.
REQ-030 Queue entries SHALL be written to the register file in enqueue order.

Reset
REQ-031 While rst_n = 0, and immediately on its assertion: write = 0, writeReg = 0, writeData = 0, pending = 0, counter = 0, stall_alu = 0, err_drop = 0, load_ready = 1.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no write SHALL occur on the first edge after deassertion unless a request is present in that cycle.

Verification
REQ-033 ALU rd = 5, data = 0x1234, queue empty -> next edge: write = 1, writeReg = 5, writeData = 0x1234.
REQ-034 Enqueue loads rd = 1, 2, 3, 4 with no ALU activity -> writes appear in order 1, 2, 3, 4 on consecutive cycles; pending reaches 0 one edge after the last pop.
REQ-035 Queue holds rd = 7 and the ALU is valid every cycle with rd = 9 -> 3 ALU writes, then stall_alu = 1 and a write to reg 7; counter returns to 0.
REQ-036 Fill 4 entries with no pops -> load_ready = 0 and pending = 4; further load_valid is not accepted; after one pop, load_ready = 1.
REQ-037 ALU request with alu_rd = 0 and queue head rd = 0 -> head popped, write = 0; ALU request during stall_alu -> err_drop = 1.
REQ-038 rst_n pulsed low with 3 entries queued -> pending = 0 and write = 0 immediately; no stale writes after release.
